// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART frame receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Index width for a counter/array of n entries, never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload byte buffer, sync write / async read
module uart_frame_buf
    import uart_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = idx_width(MAX_LEN)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_d,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_d
);

    logic [7:0] mem [MAX_LEN];

    // Store one payload byte per accepted write
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_d;
        end
    end

    assign rd_d = mem[rd_idx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - SOF/LEN/payload/checksum frame parser with drain stream
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 8680,
    parameter logic [7:0] SOF          = SOF_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_d_i,
    input  logic       rx_done_i,
    output logic [7:0] out_d_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       frame_ok_o,
    output logic       err_o,
    output logic [1:0] err_code_o,
    output logic       overrun_o
);

    localparam int             IDX_W     = idx_width(MAX_LEN);
    localparam int             TO_W      = idx_width(TIMEOUT_CLKS);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    state_t           state;
    logic [IDX_W-1:0] len_m1;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       csum;
    logic [7:0]       csum_sum;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       buf_rd_d;
    logic             buf_wr_en;
    logic             len_bad;

    assign csum_sum  = csum + rx_d_i;
    assign buf_wr_en = (state == ST_PAYLOAD) && rx_done_i;
    assign len_bad   = (rx_d_i == 8'd0) || (rx_d_i > MAX_LEN_B);

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (buf_wr_en),
        .wr_idx (wr_idx),
        .wr_d   (rx_d_i),
        .rd_idx (rd_idx),
        .rd_d   (buf_rd_d)
    );

    // Data/last are forced low outside DRAIN so stale buffer contents never leak out
    assign out_d_o    = out_valid_o ? buf_rd_d : 8'h00;
    assign out_last_o = out_valid_o && (rd_idx == len_m1);

    // Frame parser, checksum accumulator, inter-byte timeout and drain control
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_HUNT;
            len_m1      <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            csum        <= 8'h00;
            to_cnt      <= '0;
            out_valid_o <= 1'b0;
            frame_ok_o  <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
            overrun_o   <= 1'b0;
        end else begin
            frame_ok_o <= 1'b0;
            err_o      <= 1'b0;
            overrun_o  <= 1'b0;

            case (state)
                ST_HUNT: begin
                    to_cnt <= '0;
                    if (rx_done_i && (rx_d_i == SOF)) begin
                        state <= ST_LEN;
                    end
                end

                ST_LEN, ST_PAYLOAD, ST_CSUM: begin
                    if (!rx_done_i) begin
                        // A byte on the terminal cycle takes the other branch, so it always wins
                        if (to_cnt == TO_LAST) begin
                            to_cnt     <= '0;
                            err_o      <= 1'b1;
                            err_code_o <= ERR_TIMEOUT;
                            state      <= ST_HUNT;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end else begin
                        to_cnt <= '0;
                        case (state)
                            ST_LEN: begin
                                if (len_bad) begin
                                    err_o      <= 1'b1;
                                    err_code_o <= ERR_LEN;
                                    state      <= ST_HUNT;
                                end else begin
                                    len_m1 <= IDX_W'(rx_d_i - 8'd1);
                                    csum   <= rx_d_i;
                                    wr_idx <= '0;
                                    state  <= ST_PAYLOAD;
                                end
                            end
                            ST_PAYLOAD: begin
                                csum   <= csum_sum;
                                wr_idx <= wr_idx + IDX_W'(1);
                                if (wr_idx == len_m1) begin
                                    state <= ST_CSUM;
                                end
                            end
                            default: begin
                                if (csum_sum == 8'h00) begin
                                    frame_ok_o  <= 1'b1;
                                    rd_idx      <= '0;
                                    out_valid_o <= 1'b1;
                                    state       <= ST_DRAIN;
                                end else begin
                                    err_o      <= 1'b1;
                                    err_code_o <= ERR_CSUM;
                                    state      <= ST_HUNT;
                                end
                            end
                        endcase
                    end
                end

                ST_DRAIN: begin
                    to_cnt <= '0;
                    if (rx_done_i) begin
                        overrun_o <= 1'b1;
                    end
                    if (out_valid_o && out_ready_i) begin
                        if (rd_idx == len_m1) begin
                            out_valid_o <= 1'b0;
                            state       <= ST_HUNT;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                        end
                    end
                end

                default: begin
                    out_valid_o <= 1'b0;
                    state       <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

    localparam int TO_CLKS = 20;
    localparam int EV_OK   = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_OVR  = 3;

    logic       clk;
    logic       reset;
    logic [7:0] rx_d;
    logic       rx_done;
    logic [7:0] out_d;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       err;
    logic [1:0] err_code;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_mode = 0;

    logic [8:0] q_byte [$];
    logic [3:0] q_evt  [$];
    logic [7:0] stim   [$];
    logic [8:0] mon_exp;
    logic [3:0] mon_evt;

    uart_rx_frame_ctrl #(
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (TO_CLKS),
        .SOF          (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_d_i      (rx_d),
        .rx_done_i   (rx_done),
        .out_d_o     (out_d),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .frame_ok_o  (frame_ok),
        .err_o       (err),
        .err_code_o  (err_code),
        .overrun_o   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_byte(input logic [7:0] d, input logic last);
        q_byte.push_back({last, d});
    endtask

    task automatic exp_evt(input int kind, input int code);
        q_evt.push_back({2'(kind), 2'(code)});
    endtask

    task automatic pop_evt(input int kind, input int code);
        if (q_evt.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d code %0d, none expected at %0t", kind, code, $time);
        end else begin
            mon_evt = q_evt.pop_front();
            check("event_kind", kind, int'(mon_evt[3:2]));
            if (kind == EV_ERR) check("event_err_code", code, int'(mon_evt[1:0]));
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = toggling, 2 = stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: sampled after the negedge input updates, so ready reflects the next posedge
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            if (frame_ok)  pop_evt(EV_OK, 0);
            if (err)       pop_evt(EV_ERR, int'(err_code));
            if (overrun)   pop_evt(EV_OVR, 0);
            if (out_valid) begin
                if (q_byte.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got d=%02h last=%0d, none expected at %0t", out_d, out_last, $time);
                end else begin
                    mon_exp = q_byte[0];
                    check("out_d", int'(out_d), int'(mon_exp[7:0]));
                    check("out_last", int'(out_last), int'(mon_exp[8]));
                    if (out_ready) void'(q_byte.pop_front());
                end
            end
        end
    end

    task automatic drive_now(input logic [7:0] b);
        rx_d    = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        drive_now(b);
    endtask

    task automatic send_stim();
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (out_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_done", int'(out_valid), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        q_byte.delete();
        @(negedge clk);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_d"}, int'(out_d), 0);
        check({tag, "_last"}, int'(out_last), 0);
        check({tag, "_pulses"}, int'({frame_ok, err, overrun}), 0);
        check({tag, "_code"}, int'(err_code), 0);
        reset = 1'b0;
    endtask

    initial begin
        logic early;
        reset   = 1'b1;
        rx_d    = 8'h00;
        rx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_d", int'(out_d), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_ok", int'(frame_ok), 0);
        check("rst_err", int'(err), 0);
        check("rst_code", int'(err_code), 0);
        check("rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        idle(2);

        // Garbage before SOF is silently ignored
        stim = '{8'h00, 8'hFF, 8'h5A};
        send_stim();
        idle(2);
        check("garbage_quiet", int'({frame_ok, err, overrun, out_valid}), 0);

        // Good frame: 03+11+22+33 = 69, checksum byte 97 brings the sum to 00
        exp_evt(EV_OK, 0);
        exp_byte(8'h11, 0); exp_byte(8'h22, 0); exp_byte(8'h33, 1);
        stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_stim();
        check("good_latency_valid", int'(out_valid), 1);
        wait_idle();

        // Same payload with checksum 89 sums to F2 -> checksum error
        exp_evt(EV_ERR, 2);
        stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h89};
        send_stim();
        idle(3);

        // Bad checksum 02+10+20+00 = 32, then a good single-byte frame
        exp_evt(EV_ERR, 2);
        stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
        send_stim();
        idle(2);
        check("csum_err_code", int'(err_code), 2);
        exp_evt(EV_OK, 0);
        exp_byte(8'h7F, 1);
        stim = '{8'hA5, 8'h01, 8'h7F, 8'h80};
        send_stim();
        wait_idle();
        check("err_code_held", int'(err_code), 2);

        // Length errors: zero and MAX_LEN+1
        exp_evt(EV_ERR, 1);
        stim = '{8'hA5, 8'h00};
        send_stim();
        idle(2);
        check("len0_code", int'(err_code), 1);
        exp_evt(EV_ERR, 1);
        stim = '{8'hA5, 8'h11};
        send_stim();
        idle(2);
        check("len17_code", int'(err_code), 1);

        // Maximum length 16, payload 01..10, sum 98 -> checksum 68, toggling ready
        ready_mode = 1;
        exp_evt(EV_OK, 0);
        stim = '{8'hA5, 8'h10};
        for (int i = 1; i <= 16; i++) begin
            stim.push_back(8'(i));
            exp_byte(8'(i), i == 16);
        end
        stim.push_back(8'h68);
        send_stim();
        wait_idle();

        // Backpressure on a 3-byte frame: 03+01+02+03 = 09 -> F7
        exp_evt(EV_OK, 0);
        exp_byte(8'h01, 0); exp_byte(8'h02, 0); exp_byte(8'h03, 1);
        stim = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
        send_stim();
        wait_idle();
        ready_mode = 0;
        idle(2);

        // Timeout fires exactly TO_CLKS cycles after the last byte
        exp_evt(EV_ERR, 3);
        stim = '{8'hA5, 8'h02, 8'h10};
        send_stim();
        early = 1'b0;
        for (int i = 0; i < TO_CLKS - 1; i++) begin
            @(negedge clk);
            if (err) early = 1'b1;
        end
        check("timeout_early", int'(early), 0);
        @(negedge clk);
        check("timeout_exact", int'(err), 1);
        check("timeout_code", int'(err_code), 3);
        idle(2);

        // Byte on the terminal cycle suppresses the timeout: 02+10+20 = 32 -> CE
        exp_evt(EV_OK, 0);
        exp_byte(8'h10, 0); exp_byte(8'h20, 1);
        stim = '{8'hA5, 8'h02, 8'h10};
        send_stim();
        repeat (TO_CLKS - 1) @(negedge clk);
        drive_now(8'h20);
        check("timeout_suppressed", int'(err), 0);
        send_byte(8'hCE);
        wait_idle();

        // Overrun: byte (even SOF) arriving during a stalled drain; 02+AA+55 = 01 -> FF
        ready_mode = 2;
        exp_evt(EV_OK, 0);
        exp_byte(8'hAA, 0); exp_byte(8'h55, 1);
        exp_evt(EV_OVR, 0);
        stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFF};
        send_stim();
        send_byte(8'hA5);
        check("overrun_pulse", int'(overrun), 1);
        ready_mode = 0;
        wait_idle();
        exp_evt(EV_OK, 0);
        exp_byte(8'h7F, 1);
        stim = '{8'hA5, 8'h01, 8'h7F, 8'h80};
        send_stim();
        wait_idle();

        // Reset mid-payload, then a good frame 01+42 = 43 -> BD
        stim = '{8'hA5, 8'h03, 8'h11};
        send_stim();
        do_reset("rst_payload");
        exp_evt(EV_OK, 0);
        exp_byte(8'h42, 1);
        stim = '{8'hA5, 8'h01, 8'h42, 8'hBD};
        send_stim();
        wait_idle();

        // Reset mid-drain discards the held frame, then a good frame follows
        ready_mode = 2;
        exp_evt(EV_OK, 0);
        exp_byte(8'h42, 1);
        stim = '{8'hA5, 8'h01, 8'h42, 8'hBD};
        send_stim();
        idle(2);
        do_reset("rst_drain");
        ready_mode = 0;
        exp_evt(EV_OK, 0);
        exp_byte(8'hAA, 0); exp_byte(8'h55, 1);
        stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFF};
        send_stim();
        wait_idle();

        idle(5);
        check("leftover_events", q_evt.size(), 0);
        check("leftover_bytes", q_byte.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
